// File: rtl/interrupt_ack_sequencer_pkg.sv
// rtl/interrupt_ack_sequencer_pkg.sv - shared types and constants for the interrupt acknowledge sequencer
package pic_pkg;

    localparam int NUM_IRQ = 8;
    localparam int CYCLE_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2
    } state_t;

    localparam logic [7:0]         OPCODE_CALL      = 8'hCD;
    localparam logic [CYCLE_W-1:0] INTA_PULSES_8086 = 3'd2;
    localparam logic [CYCLE_W-1:0] INTA_PULSES_8080 = 3'd3;
    localparam logic [2:0]         SPURIOUS_ID      = 3'd7;

    // Position of a level in the priority order: 0 = highest, 7 = the lowest-priority level.
    function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] lowest);
        return level - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// rtl/interrupt_ack_sequencer_if.sv - request, INTA and data-bus signal bundle for the sequencer
interface interrupt_ack_sequencer_if;
    import pic_pkg::*;

    logic               inta_n;
    logic [NUM_IRQ-1:0] irr_masked;
    logic               mode_8086;
    logic               auto_eoi;
    logic               eoi_pulse;
    logic [4:0]         vector_base;
    logic               single_mode_flag;
    logic               sp_neg;
    logic [NUM_IRQ-1:0] slaves_connected_flag;
    logic               slave_active_interrupt_flag;

    logic               int_out;
    logic [CYCLE_W-1:0] interrupt_cycle_counter;
    logic [2:0]         interrupt_id;
    logic [NUM_IRQ-1:0] isr;
    logic [NUM_IRQ-1:0] clear_irr;
    logic [7:0]         data_out;
    logic               data_out_en;

    // Sequencer side.
    modport master (
        input  inta_n, irr_masked, mode_8086, auto_eoi, eoi_pulse, vector_base,
               single_mode_flag, sp_neg, slaves_connected_flag, slave_active_interrupt_flag,
        output int_out, interrupt_cycle_counter, interrupt_id, isr, clear_irr,
               data_out, data_out_en
    );

    // CPU / register-file side.
    modport slave (
        output inta_n, irr_masked, mode_8086, auto_eoi, eoi_pulse, vector_base,
               single_mode_flag, sp_neg, slaves_connected_flag, slave_active_interrupt_flag,
        input  int_out, interrupt_cycle_counter, interrupt_id, isr, clear_irr,
               data_out, data_out_en
    );

endinterface

// File: rtl/interrupt_ack_sequencer_priority_resolver.sv
// rtl/interrupt_ack_sequencer_priority_resolver.sv - highest-priority set bit under a rotatable order
module priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    input  logic [2:0]         lowest,
    output logic               valid,
    output logic [2:0]         idx
);

    logic [2:0] lvl;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        lvl   = 3'd0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            lvl = lowest + 3'd1 + 3'(k);
            if (req[lvl]) begin
                valid = 1'b1;
                idx   = lvl;
            end
        end
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// rtl/interrupt_ack_sequencer.sv - INT/INTA sequencing, ISR upkeep and vector drive; AUTO_ROTATE_EN enables rotating priority
module interrupt_ack_sequencer
    import pic_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    interrupt_ack_sequencer_if.master bus
);

    state_t             state;
    state_t             state_next;
    logic               inta_prev;
    logic               inta_fall;
    logic               inta_rise;
    logic [2:0]         lowest;
    logic               irr_valid;
    logic               isr_valid;
    logic [2:0]         irr_idx;
    logic [2:0]         isr_idx;
    logic               eligible;
    logic [CYCLE_W-1:0] cycle_cnt;
    logic [CYCLE_W-1:0] final_cnt;
    logic [2:0]         int_id;
    logic [NUM_IRQ-1:0] isr_q;
    logic [NUM_IRQ-1:0] isr_next;
    logic [NUM_IRQ-1:0] clear_q;
    logic               spurious;
    logic               ack_start;
    logic               ack_done;
    logic               set_isr;
    logic               eoi_hit;
    logic               auto_clear;
    logic               drive_phase;
    logic               drive_qual;
    logic               call_qual;
    logic               byte_en;
    logic [7:0]         byte_val;
    logic [7:0]         vector_byte;

    assign inta_fall  = inta_prev & ~bus.inta_n;
    assign inta_rise  = ~inta_prev & bus.inta_n;
    assign ack_start  = (state == PENDING) && inta_fall;
    assign ack_done   = (state == ACK) && inta_rise && (cycle_cnt == final_cnt);
    assign set_isr    = ack_start && eligible;
    assign eoi_hit    = bus.eoi_pulse && isr_valid;
    assign auto_clear = ack_done && bus.auto_eoi && !spurious;

`ifdef AUTO_ROTATE_EN
    logic [2:0] rot_ptr;

    // The level just released by an EOI becomes the lowest priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rot_ptr <= 3'd7;
        end else if (auto_clear) begin
            rot_ptr <= int_id;
        end else if (eoi_hit) begin
            rot_ptr <= isr_idx;
        end
    end

    assign lowest = rot_ptr;
`else
    assign lowest = 3'd7;
`endif

    priority_resolver u_irr_resolver (
        .req    (bus.irr_masked),
        .lowest (lowest),
        .valid  (irr_valid),
        .idx    (irr_idx)
    );

    priority_resolver u_isr_resolver (
        .req    (isr_q),
        .lowest (lowest),
        .valid  (isr_valid),
        .idx    (isr_idx)
    );

    // A request only interrupts when it outranks everything already in service.
    always_comb begin
        eligible = 1'b0;
        if (irr_valid) begin
            eligible = !isr_valid || (prio_rank(irr_idx, lowest) < prio_rank(isr_idx, lowest));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: request -> INT pending -> INTA pulses -> idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (eligible)  state_next = PENDING;
            PENDING: if (inta_fall) state_next = ACK;
            ACK:     if (ack_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ISR update: EOI works on the pre-update ISR, then the new level is set.
    always_comb begin
        isr_next = isr_q;
        if (eoi_hit) begin
            isr_next[isr_idx] = 1'b0;
        end
        if (auto_clear) begin
            isr_next[int_id] = 1'b0;
        end
        if (set_isr) begin
            isr_next[irr_idx] = 1'b1;
        end
    end

    // Acknowledge bookkeeping: INTA edge history, pulse counter, frozen id, ISR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inta_prev <= 1'b1;
            cycle_cnt <= '0;
            final_cnt <= INTA_PULSES_8080;
            int_id    <= 3'd0;
            isr_q     <= '0;
            clear_q   <= '0;
            spurious  <= 1'b0;
        end else begin
            inta_prev <= bus.inta_n;
            isr_q     <= isr_next;
            clear_q   <= '0;
            if (ack_start) begin
                cycle_cnt <= CYCLE_W'(1);
                final_cnt <= bus.mode_8086 ? INTA_PULSES_8086 : INTA_PULSES_8080;
                if (eligible) begin
                    int_id   <= irr_idx;
                    clear_q  <= NUM_IRQ'(1) << irr_idx;
                    spurious <= 1'b0;
                end else begin
                    int_id   <= SPURIOUS_ID;
                    spurious <= 1'b1;
                end
            end else if (state == ACK) begin
                if (ack_done) begin
                    cycle_cnt <= '0;
                end else if (inta_fall && (cycle_cnt != final_cnt)) begin
                    cycle_cnt <= cycle_cnt + CYCLE_W'(1);
                end
            end
        end
    end

    // Outputs: INT while pending, and the byte selected by pulse number and cascade role.
    always_comb begin
        drive_phase = (state == ACK) && !bus.inta_n && !inta_prev;
        call_qual   = bus.single_mode_flag || bus.sp_neg;
        if (bus.single_mode_flag) begin
            drive_qual = 1'b1;
        end else if (bus.sp_neg) begin
            drive_qual = !bus.slaves_connected_flag[int_id];
        end else begin
            drive_qual = bus.slave_active_interrupt_flag;
        end
        vector_byte = {bus.vector_base, int_id};
        byte_en     = 1'b0;
        byte_val    = 8'h00;
        if (final_cnt == INTA_PULSES_8086) begin
            if (cycle_cnt == CYCLE_W'(2)) begin
                byte_en  = drive_qual;
                byte_val = vector_byte;
            end
        end else begin
            case (cycle_cnt)
                CYCLE_W'(1): begin
                    byte_en  = call_qual;
                    byte_val = OPCODE_CALL;
                end
                CYCLE_W'(2): begin
                    byte_en  = drive_qual;
                    byte_val = vector_byte;
                end
                CYCLE_W'(3): begin
                    byte_en  = drive_qual;
                    byte_val = 8'h00;
                end
                default: begin
                    byte_en  = 1'b0;
                    byte_val = 8'h00;
                end
            endcase
        end
        bus.int_out     = (state == PENDING);
        bus.data_out_en = drive_phase && byte_en;
        bus.data_out    = (drive_phase && byte_en) ? byte_val : 8'h00;
    end

    assign bus.interrupt_cycle_counter = cycle_cnt;
    assign bus.interrupt_id            = int_id;
    assign bus.isr                     = isr_q;
    assign bus.clear_irr               = clear_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// tb/tb_interrupt_ack_sequencer.sv - self-checking bench for interrupt_ack_sequencer
module tb_interrupt_ack_sequencer;
    import pic_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    interrupt_ack_sequencer_if bus ();

    interrupt_ack_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] cnt;
        logic       en;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] irr;
        logic       m8086;
        logic [4:0] vb;
        logic       single;
        logic       spn;
        logic [7:0] slaves;
        logic       sact;
        logic       withdraw;
        logic [2:0] exp_id;
        logic [7:0] exp_clr;
        logic [7:0] exp_isr;
        logic [2:0] en_mask;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.inta_n = 1'b1;
        bus.irr_masked = '0;
        bus.mode_8086 = 1'b1;
        bus.auto_eoi = 1'b0;
        bus.eoi_pulse = 1'b0;
        bus.vector_base = '0;
        bus.single_mode_flag = 1'b1;
        bus.sp_neg = 1'b1;
        bus.slaves_connected_flag = '0;
        bus.slave_active_interrupt_flag = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_int_out", bus.int_out, 0);
        check("rst_counter", bus.interrupt_cycle_counter, 0);
        check("rst_id", bus.interrupt_id, 0);
        check("rst_isr", bus.isr, 0);
        check("rst_clear_irr", bus.clear_irr, 0);
        check("rst_data_out_en", bus.data_out_en, 0);
    endtask

    task automatic wait_int();
        for (int i = 0; i < 10; i++) begin
            if (bus.int_out) break;
            tick();
        end
        check("int_out_rise", bus.int_out, 1);
    endtask

    // One INTA pulse; the expected counter/byte is taken from the scoreboard mid-pulse.
    task automatic pulse(input logic with_eoi, output logic [7:0] clr);
        exp_t e;
        bus.inta_n = 1'b0;
        if (with_eoi) bus.eoi_pulse = 1'b1;
        tick();
        bus.eoi_pulse = 1'b0;
        @(negedge clk);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check("pulse_counter", bus.interrupt_cycle_counter, e.cnt);
            check("pulse_data_en", bus.data_out_en, e.en);
            if (e.en) check("pulse_data", bus.data_out, e.data);
        end
        clr = bus.clear_irr;
        tick();
        bus.inta_n = 1'b1;
        tick();
    endtask

    task automatic ack(input logic [2:0] exp_id, input logic [7:0] exp_clr, input logic [2:0] en_mask,
                       input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3, input logic eoi_first);
        logic [7:0] bytes[3];
        logic [7:0] clr;
        exp_t       e;
        int         n;
        bytes[0] = b1;
        bytes[1] = b2;
        bytes[2] = b3;
        n = bus.mode_8086 ? 2 : 3;
        for (int p = 1; p <= n; p++) begin
            e.cnt  = 3'(p);
            e.en   = en_mask[p-1];
            e.data = bytes[p-1];
            sb.push_back(e);
            pulse(eoi_first && (p == 1), clr);
            if (p == 1) begin
                check("clear_irr", clr, exp_clr);
                check("interrupt_id", bus.interrupt_id, exp_id);
                check("int_out_low", bus.int_out, 0);
                bus.irr_masked = '0;
            end
        end
        check("counter_idle", bus.interrupt_cycle_counter, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] clr;
        exp_t       e;

        vecs[0] = '{irr:8'h08, m8086:1'b1, vb:5'b01000, single:1'b1, spn:1'b0, slaves:8'h00, sact:1'b0, withdraw:1'b0,
                    exp_id:3'd3, exp_clr:8'h08, exp_isr:8'h08, en_mask:3'b010, b1:8'h00, b2:8'h43, b3:8'h00};
        vecs[1] = '{irr:8'h20, m8086:1'b0, vb:5'b10000, single:1'b1, spn:1'b0, slaves:8'h00, sact:1'b0, withdraw:1'b0,
                    exp_id:3'd5, exp_clr:8'h20, exp_isr:8'h20, en_mask:3'b111, b1:8'hCD, b2:8'h85, b3:8'h00};
        vecs[2] = '{irr:8'h04, m8086:1'b1, vb:5'b00100, single:1'b0, spn:1'b1, slaves:8'h04, sact:1'b0, withdraw:1'b0,
                    exp_id:3'd2, exp_clr:8'h04, exp_isr:8'h04, en_mask:3'b000, b1:8'h00, b2:8'h00, b3:8'h00};
        vecs[3] = '{irr:8'h81, m8086:1'b0, vb:5'b00001, single:1'b0, spn:1'b0, slaves:8'h00, sact:1'b1, withdraw:1'b0,
                    exp_id:3'd0, exp_clr:8'h01, exp_isr:8'h01, en_mask:3'b110, b1:8'h00, b2:8'h08, b3:8'h00};
        vecs[4] = '{irr:8'h60, m8086:1'b1, vb:5'b11111, single:1'b0, spn:1'b1, slaves:8'h00, sact:1'b0, withdraw:1'b0,
                    exp_id:3'd5, exp_clr:8'h20, exp_isr:8'h20, en_mask:3'b010, b1:8'h00, b2:8'hFD, b3:8'h00};
        vecs[5] = '{irr:8'h40, m8086:1'b0, vb:5'b01010, single:1'b0, spn:1'b1, slaves:8'h40, sact:1'b0, withdraw:1'b0,
                    exp_id:3'd6, exp_clr:8'h40, exp_isr:8'h40, en_mask:3'b001, b1:8'hCD, b2:8'h00, b3:8'h00};
        vecs[6] = '{irr:8'h10, m8086:1'b1, vb:5'b00110, single:1'b1, spn:1'b0, slaves:8'h00, sact:1'b0, withdraw:1'b1,
                    exp_id:3'd7, exp_clr:8'h00, exp_isr:8'h00, en_mask:3'b010, b1:8'h00, b2:8'h37, b3:8'h00};
        vecs[7] = '{irr:8'h10, m8086:1'b0, vb:5'b00110, single:1'b0, spn:1'b0, slaves:8'h00, sact:1'b0, withdraw:1'b0,
                    exp_id:3'd4, exp_clr:8'h10, exp_isr:8'h10, en_mask:3'b000, b1:8'h00, b2:8'h00, b3:8'h00};

        for (int r = 0; r < 8; r++) begin
            do_reset();
            bus.mode_8086 = vecs[r].m8086;
            bus.vector_base = vecs[r].vb;
            bus.single_mode_flag = vecs[r].single;
            bus.sp_neg = vecs[r].spn;
            bus.slaves_connected_flag = vecs[r].slaves;
            bus.slave_active_interrupt_flag = vecs[r].sact;
            bus.irr_masked = vecs[r].irr;
            wait_int();
            if (vecs[r].withdraw) begin
                bus.irr_masked = '0;
                tick();
            end
            ack(vecs[r].exp_id, vecs[r].exp_clr, vecs[r].en_mask, vecs[r].b1, vecs[r].b2, vecs[r].b3, 1'b0);
            check("row_isr", bus.isr, vecs[r].exp_isr);
            check("row_id_held", bus.interrupt_id, vecs[r].exp_id);
        end

        // INTA pulses with nothing pending are ignored.
        do_reset();
        bus.inta_n = 1'b0;
        tick();
        @(negedge clk);
        check("idle_counter", bus.interrupt_cycle_counter, 0);
        check("idle_data_en", bus.data_out_en, 0);
        tick();
        bus.inta_n = 1'b1;
        tick();

        // Nesting: lower priority blocked, higher priority nests, EOI clears the top level only.
        do_reset();
        bus.irr_masked = 8'h04;
        wait_int();
        ack(3'd2, 8'h04, 3'b010, 8'h00, 8'h02, 8'h00, 1'b0);
        check("nest_isr_a", bus.isr, 8'h04);
        bus.irr_masked = 8'h20;
        repeat (4) tick();
        check("blocked_int_out", bus.int_out, 0);
        bus.irr_masked = 8'h02;
        wait_int();
        ack(3'd1, 8'h02, 3'b010, 8'h00, 8'h01, 8'h00, 1'b0);
        check("nest_isr_b", bus.isr, 8'h06);
        bus.eoi_pulse = 1'b1;
        tick();
        bus.eoi_pulse = 1'b0;
        check("eoi_clears_top", bus.isr, 8'h04);

        // EOI on the same edge as an ISR set acts on the old ISR; the new bit stays.
        bus.irr_masked = 8'h02;
        wait_int();
        ack(3'd1, 8'h02, 3'b010, 8'h00, 8'h01, 8'h00, 1'b1);
        check("eoi_coincide_isr", bus.isr, 8'h02);
        bus.eoi_pulse = 1'b1;
        tick();
        bus.eoi_pulse = 1'b0;
        check("eoi_to_empty", bus.isr, 8'h00);
        bus.eoi_pulse = 1'b1;
        tick();
        bus.eoi_pulse = 1'b0;
        check("eoi_empty_ignored", bus.isr, 8'h00);

        // Automatic EOI, then a reset in the middle of pulse 2.
        do_reset();
        bus.auto_eoi = 1'b1;
        bus.vector_base = 5'b01000;
        bus.irr_masked = 8'h08;
        wait_int();
        ack(3'd3, 8'h08, 3'b010, 8'h00, 8'h43, 8'h00, 1'b0);
        check("auto_eoi_isr", bus.isr, 8'h00);
        bus.irr_masked = 8'h08;
        wait_int();
        e.cnt = 3'd1;
        e.en = 1'b0;
        e.data = 8'h00;
        sb.push_back(e);
        pulse(1'b0, clr);
        bus.irr_masked = '0;
        bus.inta_n = 1'b0;
        tick();
        @(negedge clk);
        check("mid_data_en", bus.data_out_en, 1);
        check("mid_data", bus.data_out, 8'h43);
        check("mid_isr", bus.isr, 8'h08);
        reset = 1'b1;
        #1;
        check("async_data_en", bus.data_out_en, 0);
        check("async_counter", bus.interrupt_cycle_counter, 0);
        check("async_isr", bus.isr, 0);
        check("async_id", bus.interrupt_id, 0);
        check("async_int_out", bus.int_out, 0);
        check("async_clear_irr", bus.clear_irr, 0);
        bus.inta_n = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
Name: interrupt_ack_sequencer

Overview:
- Upstream feeder of the cascade status logic in the 8259-style PIC.
- Resolves the winning request, raises INT, and counts CPU INTA pulses into interrupt_cycle_counter.
- Freezes interrupt_id, maintains the in-service register (ISR) and drives the vector byte(s) onto the data bus.
- Its interrupt_cycle_counter and interrupt_id outputs feed the cascade status block directly; its slave_active_interrupt_flag input comes back from that block.

Parameters:
- NUM_IRQ, 8, number of request lines; fixed at 8 for 8259 compatibility.
- CYCLE_W, 3, width of interrupt_cycle_counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- inta_n  input  1  CPU interrupt-acknowledge strobe, active-low, synchronous to clk
- irr_masked  input  8  pending requests after IMR masking; bit 0 = IR0
- mode_8086  input  1  1: two-pulse INTA (8086); 0: three-pulse INTA (8080)
- auto_eoi  input  1  clear the ISR bit automatically at end of acknowledge
- eoi_pulse  input  1  one-cycle non-specific EOI command
- vector_base  input  5  ICW2 T7..T3
- single_mode_flag  input  1  no cascade
- sp_neg  input  1  1 = master, 0 = slave
- slaves_connected_flag  input  8  ICW3 (master)
- slave_active_interrupt_flag  input  1  slave addressed on the cascade lines
- int_out  output  1  INT to CPU
- interrupt_cycle_counter  output  3  0 idle; n = nth INTA pulse of the current acknowledge
- interrupt_id  output  3  frozen id of the acknowledged level
- isr  output  8  in-service register
- clear_irr  output  8  one-cycle one-hot pulse clearing the acknowledged IRR bit
- data_out  output  8  byte for the data bus
- data_out_en  output  1  drive enable for data_out

Behaviour:
- Reset (async): all outputs 0; state IDLE; inta_n edge register reset to 1.
- Edge detection: inta_n registered once; fall = prev 1 and now 0; rise = prev 0 and now 1.
- Priority: fixed, IR0 highest.
  - "eligible" = the highest set irr_masked bit is strictly higher priority than the highest set isr bit.
  - If isr is 0, any set irr_masked bit is eligible.
- Final pulse count N = 2 when mode_8086 = 1, N = 3 when mode_8086 = 0; sampled at the first fall.
- FSM states: IDLE, PENDING, ACK.
- IDLE:
  - If eligible: int_out <= 1, go to PENDING (1 cycle after the request appears).
  - fall/rise in IDLE are ignored; counter stays 0 and nothing is driven.
- PENDING, on fall:
  - interrupt_id <= winner; isr[winner] <= 1; clear_irr <= onehot(winner) for 1 cycle; counter <= 1; int_out <= 0; go to ACK.
  - If nothing is eligible at that fall (request withdrawn): spurious. interrupt_id <= 7, isr unchanged, no clear_irr, sequence otherwise identical.
- ACK:
  - Each further fall increments the counter (saturates at N).
  - rise while counter == N: counter <= 0; if auto_eoi and not spurious, isr[interrupt_id] <= 0; go to IDLE.
  - interrupt_id holds its value until the next acknowledge.
- Data drive: data_out_en = 1 only while inta_n is low in ACK and the drive qualifier holds.
  - 8086 mode:
    - pulse 1: no drive.
    - pulse 2: data_out = {vector_base, interrupt_id}.
  - 8080 mode:
    - pulse 1: 8'hCD.
    - pulse 2: {vector_base, interrupt_id}.
    - pulse 3: 8'h00.
  - Drive qualifier:
    - single_mode_flag = 1: always.
    - Master (sp_neg = 1): only if slaves_connected_flag[interrupt_id] = 0.
    - Slave: only if slave_active_interrupt_flag = 1.
  - Exception: in 8080 mode the CALL byte on pulse 1 is driven by the master and by single mode only.
- EOI:
  - eoi_pulse clears the highest-priority set isr bit; ignored when isr is 0.
  - If eoi_pulse coincides with an ISR set, the EOI acts on the pre-update isr; the new bit remains set.
- Reset mid-acknowledge: immediate return to IDLE; data_out_en drops asynchronously.

Optional Feature:
- Macro AUTO_ROTATE_EN.
- Defined:
  - A 3-bit lowest-priority pointer (reset 7) selects the rotating priority order.
  - On every EOI, including automatic EOI, the pointer <= the cleared level, so that level becomes lowest priority.
  - Eligibility and EOI selection both use the rotated order.
- Undefined: fixed priority as above; no pointer register exists.

Decomposition:
- Package pic_pkg:
  - state enum {IDLE, PENDING, ACK}.
  - OPCODE_CALL = 8'hCD.
  - INTA_PULSES_8086 = 2, INTA_PULSES_8080 = 3.
  - SPURIOUS_ID = 3'd7.
- Sub-module priority_resolver: combinational highest-priority select over 8 bits with a rotation-pointer input. It is used twice: once for the IRR winner and once for the ISR highest bit.

Test Plan:
- Single, 8086 mode; irr_masked = 8'h08, vector_base = 5'b01000; two INTA pulses:
  - int_out rises; counter goes 1 then 2; isr = 8'h08; clear_irr = 8'h08 pulse.
  - data_out = 8'h43 with data_out_en only during pulse 2.
- 8080 mode, IR5, vector_base = 5'b10000; three INTA pulses -> bytes 8'hCD, 8'h85, 8'h00 on pulses 1, 2, 3; counter returns to 0 after the third rise.
- isr = 8'h04, irr_masked = 8'h20: int_out stays 0. Then irr_masked = 8'h02: int_out rises, id = 1. Then eoi_pulse clears bit 1 only.
- Master, slaves_connected_flag = 8'h04, IR2 acknowledged -> data_out_en = 0 on pulse 2; interrupt_id = 2 throughout.
- Request dropped before the first fall -> interrupt_id = 7, isr unchanged, vector {vector_base, 3'd7}.
- auto_eoi = 1 plus reset asserted mid pulse 2: isr stays 0 across a normal acknowledge; the reset drives every output to 0 immediately.
